// File: rtl/sys_mem_pkg.sv
// Shared sizes and FSM state type for the sys_mem response block.
package sys_mem_pkg;

  localparam int unsigned MEM_BYTES = 16384;
  localparam int unsigned ADDR_W    = 14;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned RD_W      = 8;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp,
    StDrop
  } state_e;

endpackage

// File: rtl/sys_mem_array.sv
// 16K x 8 byte storage: one synchronous byte read port, one 2-byte write port.
module sys_mem_array
  import sys_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [RD_W-1:0]   rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [RD_W-1:0]   mem [MEM_BYTES];
  logic [ADDR_W-1:0] wr_addr_hi;

  // Upper byte address wraps naturally in 14 bits (16383 -> 0).
  assign wr_addr_hi = wr_addr + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr]    <= wr_data[7:0];
      mem[wr_addr_hi] <= wr_data[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sys_mem_resp.sv
// Fixed-latency memory responder: accepts one read or write from IDLE, responds after LATENCY.
module sys_mem_resp
  import sys_mem_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_req,
  input  logic              write_req,
  input  logic [ADDR_W-1:0] addrout,
  input  logic [DATA_W-1:0] datatomem,
  output logic              mem_resp,
  output logic [RD_W-1:0]   datafrommem,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CntInit = CNT_W'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic              rd_valid_q, rd_valid_d;

  logic              issue;
  logic              arr_rd_en;
  logic              arr_wr_en;
  logic [RD_W-1:0]   arr_rd_data;

  // Last WAIT cycle: the memory access lands on the edge that enters RESP.
  assign issue     = (state_q == StWait) && (cnt_q == '0);
  assign arr_rd_en = issue && !wr_q;
  assign arr_wr_en = issue && wr_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_d       = wr_q;
    rd_valid_d = rd_valid_q;
    case (state_q)
      StIdle: begin
        if (read_req || write_req) begin
          state_d = StWait;
          cnt_d   = CntInit;
          addr_d  = addrout;
          data_d  = datatomem;
          wr_d    = write_req;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          if (!wr_q) begin
            rd_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StResp: begin
        state_d = StDrop;
      end
      StDrop: begin
        if (!read_req && !write_req) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  sys_mem_array u_array (
    .clk     (clk),
    .rd_en   (arr_rd_en),
    .rd_addr (addr_q),
    .rd_data (arr_rd_data),
    .wr_en   (arr_wr_en),
    .wr_addr (addr_q),
    .wr_data (data_q)
  );

  // The array read register has no reset, so mask it until the first read response.
  assign datafrommem = rd_valid_q ? arr_rd_data : '0;
  assign mem_resp    = (state_q == StResp);
  assign busy        = (state_q != StIdle);

endmodule
